// File: rtl/xbar_arb_pkg.sv
// Shared types and helpers for the crossbar output arbiters.
// Optional weighted round-robin is enabled with XBAR_ARB_WRR_EN.
package xbar_arb_pkg;
  localparam int unsigned MAX_PORTS = 32;
  localparam int unsigned PICK_IDW  = 5;

  typedef int unsigned uint_t;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  typedef struct packed {
    logic                found;
    logic [PICK_IDW-1:0] id;
  } pick_t;

  function automatic uint_t clog2_min1(input uint_t n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // First set bit of mask at or after ptr, searching cyclically over n bits.
  function automatic pick_t rr_pick(input logic [MAX_PORTS-1:0] mask, input uint_t ptr,
                                    input uint_t n);
    pick_t r;
    uint_t idx;
    r = '0;
    for (uint_t k = 0; k < MAX_PORTS; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!r.found && mask[idx[PICK_IDW-1:0]]) begin
          r.found = 1'b1;
          r.id    = idx[PICK_IDW-1:0];
        end
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/xbar_arb_channel.sv
// Packet-locking round-robin arbiter for one master port.
// XBAR_ARB_WRR_EN adds a per-channel packet counter and per-source weights.
module xbar_arb_channel import xbar_arb_pkg::*; #(
  parameter int unsigned S          = 2,
  parameter int unsigned MAX_WEIGHT = 4,
  parameter int unsigned IDW        = 1,
  parameter int unsigned WW         = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_in,
  input  logic [S-1:0]          i_req,
  input  logic [S-1:0]          i_valid,
  input  logic [S-1:0]          i_last,
  input  logic                  i_ready,
`ifdef XBAR_ARB_WRR_EN
  input  logic [S-1:0][WW-1:0]  i_weight,
`endif
  output logic [IDW-1:0]        o_grant_id,
  output logic                  o_grant_valid
);
  arb_state_e     r_state, w_nstate;
  logic [IDW-1:0] r_id, w_nid, r_ptr, w_nptr, w_rel_ptr;
  logic [S-1:0]   w_own;
  logic           w_release, w_keep;
  pick_t          w_pick_idle, w_pick_rel;

  assign w_release = (r_state == LOCKED) && i_valid[r_id] && i_ready && i_last[r_id];
  assign w_rel_ptr = (r_id == IDW'(S - 1)) ? '0 : r_id + 1'b1;
  assign w_own     = S'(1) << r_id;

  // The releasing source is masked so a finished packet cannot win again at once.
  assign w_pick_idle = rr_pick(MAX_PORTS'(i_req), uint_t'(r_ptr), S);
  assign w_pick_rel  = rr_pick(MAX_PORTS'(i_req & ~w_own), uint_t'(w_rel_ptr), S);

`ifdef XBAR_ARB_WRR_EN
  logic [WW-1:0] r_cnt, w_wt;
  assign w_wt   = (i_weight[r_id] == '0) ? WW'(1) : i_weight[r_id];
  assign w_keep = i_req[r_id] && ((r_cnt + 1'b1) < w_wt);

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in)        r_cnt <= '0;
    else if (w_release) r_cnt <= w_keep ? r_cnt + 1'b1 : '0;
  end
`else
  assign w_keep = 1'b0;
`endif

  always_comb begin
    w_nstate = r_state;
    w_nid    = r_id;
    w_nptr   = r_ptr;
    if (r_state == IDLE) begin
      if (w_pick_idle.found) begin
        w_nstate = LOCKED;
        w_nid    = IDW'(w_pick_idle.id);
      end
    end else if (w_release && !w_keep) begin
      w_nptr = w_rel_ptr;
      if (w_pick_rel.found) w_nid = IDW'(w_pick_rel.id);
      else                  w_nstate = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_id    <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_nstate;
      r_id    <= w_nid;
      r_ptr   <= w_nptr;
    end
  end

  assign o_grant_id    = r_id;
  assign o_grant_valid = (r_state == LOCKED);
endmodule

// File: rtl/xbar_arbiter_unit.sv
// AXI-Stream crossbar arbitration: one packet-locking arbiter per master port.
// Define XBAR_ARB_WRR_EN for weighted round-robin (adds s_weight_i).
module xbar_arbiter_unit import xbar_arb_pkg::*; #(
  parameter  int unsigned S_DATA_COUNT = 2,
  parameter  int unsigned M_DATA_COUNT = 3,
  parameter  int unsigned MAX_WEIGHT   = 4,
  localparam int unsigned T_ID___WIDTH = clog2_min1(S_DATA_COUNT),
  localparam int unsigned T_DEST_WIDTH = clog2_min1(M_DATA_COUNT),
  localparam int unsigned WW           = clog2_min1(MAX_WEIGHT + 1)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_in,
  input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]                  s_valid_i,
  input  logic [S_DATA_COUNT-1:0]                  s_last_i,
  input  logic [M_DATA_COUNT-1:0]                  m_ready_i,
`ifdef XBAR_ARB_WRR_EN
  input  logic [S_DATA_COUNT-1:0][WW-1:0]          s_weight_i,
`endif
  output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] grant_id_o,
  output logic [M_DATA_COUNT-1:0]                  grant_valid_o,
  output logic [S_DATA_COUNT-1:0]                  s_granted_o
);
  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] w_req;

  for (genvar i = 0; i < M_DATA_COUNT; i++) begin : g_ch
    // Out-of-range TDEST values never match any channel index.
    for (genvar j = 0; j < S_DATA_COUNT; j++) begin : g_req
      assign w_req[i][j] = s_valid_i[j] && (s_dest_i[j] == T_DEST_WIDTH'(i));
    end

    xbar_arb_channel #(
      .S(S_DATA_COUNT), .MAX_WEIGHT(MAX_WEIGHT), .IDW(T_ID___WIDTH), .WW(WW)
    ) u_ch (
      .clk_i         (clk_i),
      .rst_in        (rst_in),
      .i_req         (w_req[i]),
      .i_valid       (s_valid_i),
      .i_last        (s_last_i),
      .i_ready       (m_ready_i[i]),
`ifdef XBAR_ARB_WRR_EN
      .i_weight      (s_weight_i),
`endif
      .o_grant_id    (grant_id_o[i]),
      .o_grant_valid (grant_valid_o[i])
    );
  end

  always_comb begin
    s_granted_o = '0;
    for (int i = 0; i < M_DATA_COUNT; i++)
      for (int j = 0; j < S_DATA_COUNT; j++)
        if (grant_valid_o[i] && grant_id_o[i] == T_ID___WIDTH'(j)) s_granted_o[j] = 1'b1;
  end
endmodule

// File: tb/tb_xbar_arbiter_unit.sv
// Directed bench for xbar_arbiter_unit (S=3, M=3); WRR scenario runs when XBAR_ARB_WRR_EN is defined.
module tb_xbar_arbiter_unit;
  localparam int S = 3, M = 3, MW = 4, IDW = 2, DW = 2, WW = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [S-1:0][DW-1:0]   s_dest;
  logic [S-1:0]           s_valid, s_last, s_granted;
  logic [M-1:0]           m_ready, grant_valid;
  logic [M-1:0][IDW-1:0]  grant_id;
`ifdef XBAR_ARB_WRR_EN
  logic [S-1:0][WW-1:0]   s_weight;
`endif
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  xbar_arbiter_unit #(.S_DATA_COUNT(S), .M_DATA_COUNT(M), .MAX_WEIGHT(MW)) dut (
    .clk_i(clk), .rst_in(rst_n), .s_dest_i(s_dest), .s_valid_i(s_valid), .s_last_i(s_last),
    .m_ready_i(m_ready),
`ifdef XBAR_ARB_WRR_EN
    .s_weight_i(s_weight),
`endif
    .grant_id_o(grant_id), .grant_valid_o(grant_valid), .s_granted_o(s_granted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_dest = '0; s_valid = '0; s_last = '0; m_ready = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_dest = '0; s_valid = '0; s_last = '0; m_ready = '0;
    #1;
    n_tests++;
    if (grant_valid !== 3'b000 || grant_id !== 6'd0 || s_granted !== 3'b000) begin
      n_fail++; $display("FAIL reset_state gv=%b id=%h sg=%b exp 000/0/000", grant_valid, grant_id, s_granted);
    end
    #2 rst_n = 1'b1;
    // slave 1 single-beat to dest 0 moves ch0 pointer to 2
    s_valid = 3'b010; s_dest[1] = 2'd0; s_last = 3'b111; m_ready = 3'b111;
    tick();
    n_tests++;
    if (grant_valid[0] !== 1'b1 || grant_id[0] !== 2'd1) begin
      n_fail++; $display("FAIL reset_pre_grant gv=%b id=%0d exp 1/1", grant_valid[0], grant_id[0]);
    end
    tick();
    s_valid = '0;
    n_tests++;
    if (grant_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_pre_release gv=%b exp 0", grant_valid[0]);
    end
    s_valid = 3'b101; s_dest[0] = 2'd0; s_dest[2] = 2'd0; s_last = '0;
    tick();
    n_tests++;
    if (grant_valid[0] !== 1'b1 || grant_id[0] !== 2'd2) begin
      n_fail++; $display("FAIL reset_ptr2_grant gv=%b id=%0d exp 1/2", grant_valid[0], grant_id[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (grant_valid !== 3'b000 || grant_id !== 6'd0 || s_granted !== 3'b000) begin
      n_fail++; $display("FAIL reset_async gv=%b id=%h sg=%b exp 000/0/000", grant_valid, grant_id, s_granted);
    end
    #1 rst_n = 1'b1;
    tick();
    n_tests++;
    if (grant_valid[0] !== 1'b1 || grant_id[0] !== 2'd0) begin
      n_fail++; $display("FAIL reset_regrant gv=%b id=%0d exp 1/0", grant_valid[0], grant_id[0]);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_id [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
    logic [2:0] one = 3'b001;
    do_reset();
    s_valid = 3'b111; s_dest = '0; m_ready = 3'b111;
    for (int k = 0; k < 7; k++) begin
      s_last = (k >= 2 && k % 2 == 0) ? 3'b111 : 3'b000;
      tick();
      n_tests++;
      if (grant_valid[0] !== 1'b1 || grant_id[0] !== exp_id[k] || s_granted !== (one << exp_id[k])) begin
        n_fail++;
        $display("FAIL contention[%0d] gv=%b id=%0d sg=%b exp 1/%0d/%b", k, grant_valid[0],
                 grant_id[0], s_granted, exp_id[k], one << exp_id[k]);
      end
    end
  endtask

  task automatic test_lock_hold();
    do_reset();
    s_valid = 3'b010; s_dest[1] = 2'd1; m_ready = 3'b010;
    tick();
    n_tests++;
    if (grant_valid[1] !== 1'b1 || grant_id[1] !== 2'd1) begin
      n_fail++; $display("FAIL lock_first gv=%b id=%0d exp 1/1", grant_valid[1], grant_id[1]);
    end
    m_ready = '0; s_valid = 3'b011; s_dest[0] = 2'd1; s_last = 3'b010;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if (grant_valid[1] !== 1'b1 || grant_id[1] !== 2'd1 || s_granted !== 3'b010) begin
        n_fail++; $display("FAIL lock_hold[%0d] gv=%b id=%0d sg=%b exp 1/1/010", k, grant_valid[1],
                           grant_id[1], s_granted);
      end
    end
    m_ready = 3'b010;
    tick();
    n_tests++;
    if (grant_valid[1] !== 1'b1 || grant_id[1] !== 2'd0 || s_granted !== 3'b001) begin
      n_fail++; $display("FAIL lock_handover gv=%b id=%0d sg=%b exp 1/0/001", grant_valid[1],
                         grant_id[1], s_granted);
    end
  endtask

  task automatic test_release_mask();
    do_reset();
    s_valid = 3'b001; s_dest[0] = 2'd0; s_last = 3'b001; m_ready = 3'b001;
    tick();
    n_tests++;
    if (grant_valid[0] !== 1'b1 || grant_id[0] !== 2'd0) begin
      n_fail++; $display("FAIL relmask_grant gv=%b id=%0d exp 1/0", grant_valid[0], grant_id[0]);
    end
    tick();
    n_tests++;
    if (grant_valid !== 3'b000 || s_granted !== 3'b000) begin
      n_fail++; $display("FAIL relmask_idle gv=%b sg=%b exp 000/000", grant_valid, s_granted);
    end
    s_valid = '0;
    tick();
    n_tests++;
    if (grant_valid !== 3'b000) begin
      n_fail++; $display("FAIL relmask_stay_idle gv=%b exp 000", grant_valid);
    end
  endtask

  task automatic test_invalid_dest();
    do_reset();
    s_valid = 3'b001; s_dest[0] = 2'd3; m_ready = 3'b111;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_tests++;
      if (grant_valid !== 3'b000 || s_granted !== 3'b000) begin
        n_fail++; $display("FAIL invalid_dest[%0d] gv=%b sg=%b exp 000/000", k, grant_valid, s_granted);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    s_valid = 3'b111; s_dest[0] = 2'd0; s_dest[1] = 2'd1; s_dest[2] = 2'd2;
    s_last = 3'b111; m_ready = 3'b111;
    tick();
    n_tests++;
    if (grant_valid !== 3'b111 || grant_id !== {2'd2, 2'd1, 2'd0} || s_granted !== 3'b111) begin
      n_fail++; $display("FAIL b2b_grant gv=%b id=%h sg=%b exp 111/24/111", grant_valid, grant_id, s_granted);
    end
    tick();
    n_tests++;
    if (grant_valid !== 3'b000 || s_granted !== 3'b000) begin
      n_fail++; $display("FAIL b2b_release gv=%b sg=%b exp 000/000", grant_valid, s_granted);
    end
    s_valid = '0;
  endtask

`ifdef XBAR_ARB_WRR_EN
  task automatic test_wrr();
    logic [1:0] exp_id [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
    do_reset();
    s_weight = {3'd0, 3'd1, 3'd3};
    s_valid = 3'b011; s_dest = '0; s_last = 3'b111; m_ready = 3'b001;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_tests++;
      if (grant_valid[0] !== 1'b1 || grant_id[0] !== exp_id[k]) begin
        n_fail++; $display("FAIL wrr[%0d] gv=%b id=%0d exp 1/%0d", k, grant_valid[0], grant_id[0], exp_id[k]);
      end
    end
  endtask
`endif

  initial begin
`ifdef XBAR_ARB_WRR_EN
    s_weight = '0;
`endif
    test_reset();
    test_contention();
    test_lock_hold();
    test_release_mask();
    test_invalid_dest();
    test_back_to_back();
`ifdef XBAR_ARB_WRR_EN
    test_wrr();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
